// File: rtl/rx_receiver.sv
// Single-wire serial receiver: deserialises packets of 1-8 words (1-16 data bits, even parity, stop bit)
// into a one-entry valid/ack holding register.
module rx_receiver (
    input  logic        clk,
    input  logic        rst,
    input  logic        serial_in,
    input  logic [7:0]  packet_struct,
    input  logic        rx_ack,
    output logic        rx_ready,
    output logic [15:0] rx_data,
    output logic        rx_perr,
    output logic [2:0]  rx_word_idx,
    output logic        rx_valid,
    output logic        rx_done,
    output logic        frame_err
);

    // state  | meaning
    // IDLE   | waiting for a start bit (line low) while the holding register can take a word
    // DATA   | shifting in data bits, LSB first
    // PARITY | sampling the parity bit and loading the holding register
    // STOP   | checking the stop bit; ends, aborts or continues the packet
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  word_cnt_q, word_cnt_d;
    logic [15:0] asm_q, asm_d;
    logic        par_q, par_d;
    logic [15:0] rx_data_q, rx_data_d;
    logic        rx_perr_q, rx_perr_d;
    logic [2:0]  rx_word_idx_q, rx_word_idx_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_done_q, rx_done_d;
    logic        frame_err_q, frame_err_d;

    logic [3:0]  last_bit;
    logic [2:0]  last_word;
    logic        unused_pkt_bit;

    assign last_bit       = packet_struct[3:0];
    assign last_word      = packet_struct[7:5];
    assign unused_pkt_bit = packet_struct[4];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            bit_cnt_q     <= 4'd0;
            word_cnt_q    <= 3'd0;
            asm_q         <= 16'd0;
            par_q         <= 1'b0;
            rx_data_q     <= 16'd0;
            rx_perr_q     <= 1'b0;
            rx_word_idx_q <= 3'd0;
            rx_valid_q    <= 1'b0;
            rx_done_q     <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            word_cnt_q    <= word_cnt_d;
            asm_q         <= asm_d;
            par_q         <= par_d;
            rx_data_q     <= rx_data_d;
            rx_perr_q     <= rx_perr_d;
            rx_word_idx_q <= rx_word_idx_d;
            rx_valid_q    <= rx_valid_d;
            rx_done_q     <= rx_done_d;
            frame_err_q   <= frame_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        word_cnt_d    = word_cnt_q;
        asm_d         = asm_q;
        par_d         = par_q;
        rx_data_d     = rx_data_q;
        rx_perr_d     = rx_perr_q;
        rx_word_idx_d = rx_word_idx_q;
        rx_valid_d    = rx_valid_q;
        rx_done_d     = 1'b0;
        frame_err_d   = 1'b0;

        if (rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                bit_cnt_d  = 4'd0;
                word_cnt_d = 3'd0;
                asm_d      = 16'd0;
                par_d      = 1'b0;
                if (!serial_in && rx_ready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                asm_d[bit_cnt_q] = serial_in;
                par_d            = par_q ^ serial_in;
                bit_cnt_d        = bit_cnt_q + 4'd1;
                // a 16-bit word lets the counter wrap to 0 on its last bit
                if (bit_cnt_q == last_bit) begin
                    state_d = PARITY;
                end
            end
            PARITY: begin
                // load beats a simultaneous ack on the holding register
                rx_data_d     = asm_q;
                rx_perr_d     = (serial_in != par_q);
                rx_word_idx_d = word_cnt_q;
                rx_valid_d    = 1'b1;
                state_d       = STOP;
            end
            STOP: begin
                if (!serial_in) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else if (word_cnt_q == last_word) begin
                    rx_done_d = 1'b1;
                    state_d   = IDLE;
                end else if (rx_ready) begin
                    state_d    = DATA;
                    word_cnt_d = word_cnt_q + 3'd1;
                    bit_cnt_d  = 4'd0;
                    asm_d      = 16'd0;
                    par_d      = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rx_ready    = ((state_q == IDLE) || (state_q == STOP)) && (!rx_valid_q || rx_ack);
        rx_data     = rx_data_q;
        rx_perr     = rx_perr_q;
        rx_word_idx = rx_word_idx_q;
        rx_valid    = rx_valid_q;
        rx_done     = rx_done_q;
        frame_err   = frame_err_q;
    end

endmodule

// File: tb/tb_rx_receiver.sv
// Directed self-checking bench for rx_receiver: each scenario task drives a frame bit by bit and
// checks hand-computed results at fixed cycle offsets.
module tb_rx_receiver;

    logic        clk;
    logic        rst;
    logic        serial_in;
    logic [7:0]  packet_struct;
    logic        rx_ack;
    logic        rx_ready;
    logic [15:0] rx_data;
    logic        rx_perr;
    logic [2:0]  rx_word_idx;
    logic        rx_valid;
    logic        rx_done;
    logic        frame_err;

    int total;
    int bad;

    rx_receiver dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .packet_struct (packet_struct),
        .rx_ack        (rx_ack),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .rx_perr       (rx_perr),
        .rx_word_idx   (rx_word_idx),
        .rx_valid      (rx_valid),
        .rx_done       (rx_done),
        .frame_err     (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one clock; outputs are observed 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            serial_in = v[i];
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        serial_in = 1'b1;
        rx_ack = 1'b0;
        packet_struct = 8'h07;
        tick();
        tick();
        rst = 1'b0;
        total++; if (rx_valid !== 1'b0)     begin bad++; $display("FAIL reset_valid got=%b want=0", rx_valid); end
        total++; if (rx_ready !== 1'b1)     begin bad++; $display("FAIL reset_ready got=%b want=1", rx_ready); end
        total++; if (rx_data !== 16'h0000)  begin bad++; $display("FAIL reset_data got=%h want=0000", rx_data); end
        total++; if (rx_perr !== 1'b0)      begin bad++; $display("FAIL reset_perr got=%b want=0", rx_perr); end
        total++; if (rx_word_idx !== 3'd0)  begin bad++; $display("FAIL reset_idx got=%0d want=0", rx_word_idx); end
        total++; if (rx_done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b want=0", rx_done); end
        total++; if (frame_err !== 1'b0)    begin bad++; $display("FAIL reset_ferr got=%b want=0", frame_err); end
    endtask

    // one 8-bit word 0xA5; par_bit is the transmitted parity bit
    task automatic test_single_word(input logic par_bit, input logic exp_perr);
        packet_struct = 8'h07;
        rx_ack = 1'b1;
        serial_in = 1'b1;
        tick();
        serial_in = 1'b0;                 // start bit, cycle T0
        tick();
        send_bits(16'h00A5, 8);           // T0+1 .. T0+8
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL sw_valid_early got=%b want=0", rx_valid); end
        serial_in = par_bit;              // T0+9
        tick();
        total++; if (rx_valid !== 1'b1)     begin bad++; $display("FAIL sw_valid got=%b want=1", rx_valid); end
        total++; if (rx_data !== 16'h00A5)  begin bad++; $display("FAIL sw_data got=%h want=00a5", rx_data); end
        total++; if (rx_perr !== exp_perr)  begin bad++; $display("FAIL sw_perr got=%b want=%b", rx_perr, exp_perr); end
        total++; if (rx_word_idx !== 3'd0)  begin bad++; $display("FAIL sw_idx got=%0d want=0", rx_word_idx); end
        total++; if (rx_done !== 1'b0)      begin bad++; $display("FAIL sw_done_early got=%b want=0", rx_done); end
        serial_in = 1'b1;                 // stop bit
        tick();
        total++; if (rx_done !== 1'b1)      begin bad++; $display("FAIL sw_done got=%b want=1", rx_done); end
        total++; if (rx_valid !== 1'b0)     begin bad++; $display("FAIL sw_acked got=%b want=0", rx_valid); end
        tick();
        total++; if (rx_done !== 1'b0)      begin bad++; $display("FAIL sw_done_pulse got=%b want=0", rx_done); end
        total++; if (rx_ready !== 1'b1)     begin bad++; $display("FAIL sw_idle_ready got=%b want=1", rx_ready); end
    endtask

    task automatic test_back_pressure();
        logic [3:0]  words [3];
        logic        pars  [3];
        int          dones;
        words[0] = 4'h3; pars[0] = 1'b0;
        words[1] = 4'hC; pars[1] = 1'b0;
        words[2] = 4'h9; pars[2] = 1'b0;
        dones = 0;
        packet_struct = 8'h43;
        rx_ack = 1'b0;
        serial_in = 1'b1;
        tick();
        serial_in = 1'b0;
        tick();
        for (int w = 0; w < 3; w++) begin
            send_bits({12'd0, words[w]}, 4);
            serial_in = pars[w];
            tick();
            dones += int'(rx_done);
            total++; if (rx_valid !== 1'b1)        begin bad++; $display("FAIL bp_valid w=%0d got=%b want=1", w, rx_valid); end
            total++; if (rx_data !== {12'd0, words[w]}) begin bad++; $display("FAIL bp_data w=%0d got=%h want=%h", w, rx_data, words[w]); end
            total++; if (rx_word_idx !== 3'(w))   begin bad++; $display("FAIL bp_idx w=%0d got=%0d want=%0d", w, rx_word_idx, w); end
            total++; if (rx_perr !== 1'b0)        begin bad++; $display("FAIL bp_perr w=%0d got=%b want=0", w, rx_perr); end
            serial_in = 1'b1;
            if (w < 2) begin
                for (int c = 0; c < 5; c++) begin
                    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_wait w=%0d c=%0d got=%b want=0", w, c, rx_ready); end
                    tick();
                    dones += int'(rx_done);
                end
                total++; if (rx_data !== {12'd0, words[w]}) begin bad++; $display("FAIL bp_hold w=%0d got=%h want=%h", w, rx_data, words[w]); end
                rx_ack = 1'b1;
                #1;
                total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_ack w=%0d got=%b want=1", w, rx_ready); end
                tick();
                dones += int'(rx_done);
                rx_ack = 1'b0;
            end else begin
                tick();
                dones += int'(rx_done);
                total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL bp_last_held got=%b want=1", rx_valid); end
                for (int c = 0; c < 4; c++) begin
                    tick();
                    dones += int'(rx_done);
                end
                rx_ack = 1'b1;
                tick();
                dones += int'(rx_done);
                total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL bp_last_acked got=%b want=0", rx_valid); end
            end
        end
        total++; if (dones !== 1) begin bad++; $display("FAIL bp_done_count got=%0d want=1", dones); end
    endtask

    task automatic test_width16();
        packet_struct = 8'h0F;
        rx_ack = 1'b1;
        serial_in = 1'b1;
        tick();
        serial_in = 1'b0;
        tick();
        send_bits(16'hFFFF, 16);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL w16_valid_early got=%b want=0", rx_valid); end
        serial_in = 1'b0;
        tick();
        total++; if (rx_data !== 16'hFFFF) begin bad++; $display("FAIL w16_data got=%h want=ffff", rx_data); end
        total++; if (rx_perr !== 1'b0)     begin bad++; $display("FAIL w16_perr got=%b want=0", rx_perr); end
        serial_in = 1'b1;
        tick();
        total++; if (rx_done !== 1'b1)     begin bad++; $display("FAIL w16_done got=%b want=1", rx_done); end
        tick();
        total++; if (rx_ready !== 1'b1)    begin bad++; $display("FAIL w16_idle got=%b want=1", rx_ready); end
    endtask

    task automatic test_frame_error();
        int dones;
        dones = 0;
        packet_struct = 8'h27;            // 2 words x 8 bits
        rx_ack = 1'b0;
        serial_in = 1'b1;
        tick();
        serial_in = 1'b0;
        tick();
        send_bits(16'h005A, 8);
        serial_in = 1'b0;
        tick();
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL fe_valid got=%b want=1", rx_valid); end
        serial_in = 1'b0;                 // broken stop bit
        tick();
        total++; if (frame_err !== 1'b1)   begin bad++; $display("FAIL fe_pulse got=%b want=1", frame_err); end
        total++; if (rx_done !== 1'b0)     begin bad++; $display("FAIL fe_no_done got=%b want=0", rx_done); end
        total++; if (rx_valid !== 1'b1)    begin bad++; $display("FAIL fe_held got=%b want=1", rx_valid); end
        total++; if (rx_data !== 16'h005A) begin bad++; $display("FAIL fe_data got=%h want=005a", rx_data); end
        total++; if (rx_word_idx !== 3'd0) begin bad++; $display("FAIL fe_idx got=%0d want=0", rx_word_idx); end
        serial_in = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            dones += int'(rx_done);
        end
        total++; if (frame_err !== 1'b0)   begin bad++; $display("FAIL fe_pulse_end got=%b want=0", frame_err); end
        total++; if (dones !== 0)          begin bad++; $display("FAIL fe_done_count got=%0d want=0", dones); end
        total++; if (rx_valid !== 1'b1)    begin bad++; $display("FAIL fe_still_held got=%b want=1", rx_valid); end
        rx_ack = 1'b1;
        tick();
        total++; if (rx_valid !== 1'b0)    begin bad++; $display("FAIL fe_acked got=%b want=0", rx_valid); end
        total++; if (rx_ready !== 1'b1)    begin bad++; $display("FAIL fe_idle_ready got=%b want=1", rx_ready); end
    endtask

    task automatic test_reset_mid_data();
        packet_struct = 8'h07;
        rx_ack = 1'b0;
        serial_in = 1'b1;
        tick();
        serial_in = 1'b0;
        tick();
        send_bits(16'h0005, 3);           // bits 0..2
        total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b want=0", rx_ready); end
        rst = 1'b1;
        serial_in = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (rx_ready !== 1'b1)    begin bad++; $display("FAIL rm_ready got=%b want=1", rx_ready); end
        total++; if (rx_valid !== 1'b0)    begin bad++; $display("FAIL rm_valid got=%b want=0", rx_valid); end
        total++; if (rx_data !== 16'h0000) begin bad++; $display("FAIL rm_data got=%h want=0000", rx_data); end
        total++; if (rx_done !== 1'b0)     begin bad++; $display("FAIL rm_done got=%b want=0", rx_done); end
        total++; if (frame_err !== 1'b0)   begin bad++; $display("FAIL rm_ferr got=%b want=0", frame_err); end
        rx_ack = 1'b1;
        tick();
        serial_in = 1'b0;
        tick();
        send_bits(16'h003C, 8);
        serial_in = 1'b0;
        tick();
        total++; if (rx_data !== 16'h003C) begin bad++; $display("FAIL rm_next_data got=%h want=003c", rx_data); end
        total++; if (rx_perr !== 1'b0)     begin bad++; $display("FAIL rm_next_perr got=%b want=0", rx_perr); end
        total++; if (rx_valid !== 1'b1)    begin bad++; $display("FAIL rm_next_valid got=%b want=1", rx_valid); end
        serial_in = 1'b1;
        tick();
        total++; if (rx_done !== 1'b1)     begin bad++; $display("FAIL rm_next_done got=%b want=1", rx_done); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        serial_in = 1'b1;
        packet_struct = 8'h07;
        rx_ack = 1'b0;
        test_reset();
        test_single_word(1'b0, 1'b0);
        test_single_word(1'b1, 1'b1);
        test_back_pressure();
        test_width16();
        test_frame_error();
        test_reset_mid_data();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
